// File: rtl/rv_pkg.sv
// Shared RV32I decode constants for the ID stage: opcodes, ALU op classes,
// control-bundle bit positions and the immediate format selector.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // Bit positions inside id_ex_ctrl
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_e;

  function automatic logic [7:0] pack_ctrl(
    input logic       reg_write,
    input logic       mem_read,
    input logic       mem_write,
    input logic       mem_to_reg,
    input logic       alu_src,
    input logic       branch,
    input logic [1:0] alu_op
  );
    logic [7:0] c;
    c = '0;
    c[CTRL_REG_WRITE]  = reg_write;
    c[CTRL_MEM_READ]   = mem_read;
    c[CTRL_MEM_WRITE]  = mem_write;
    c[CTRL_MEM_TO_REG] = mem_to_reg;
    c[CTRL_ALU_SRC]    = alu_src;
    c[CTRL_BRANCH]     = branch;
    c[CTRL_ALU_OP_HI]  = alu_op[1];
    c[CTRL_ALU_OP_LO]  = alu_op[0];
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry architectural register file: two async read ports with
// write-through bypass, one write port committed on the rising edge.
module regfile #(
  parameter int XLEN     = 32,
  parameter bit RF_RESET = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];
  logic            wr_live;

  assign wr_live = we && (waddr != 5'd0);

  always_ff @(posedge clock) begin
    if (RF_RESET && reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // A value being written back this cycle is visible to the decode reading it.
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    if (wr_live && (waddr == raddr1)) rdata1 = wdata;
    rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
    if (wr_live && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register read, control decode, immediate
// generation, load-use hazard detection and the registered ID/EX bundle.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RF_RESET = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     if_id_instr,
  input  logic [XLEN-1:0] if_id_npc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic [7:0]      id_ex_ctrl,
  output logic            id_ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [7:0]      ctrl;
  logic            illegal;
  logic            use_rs1;
  logic            use_rs2;
  imm_fmt_e        imm_fmt;
  logic            load_use;

  assign opcode   = if_id_instr[6:0];
  assign rd       = if_id_instr[11:7];
  assign funct3   = if_id_instr[14:12];
  assign rs1      = if_id_instr[19:15];
  assign rs2      = if_id_instr[24:20];
  assign funct7b5 = if_id_instr[30];

  regfile #(
    .XLEN     (XLEN),
    .RF_RESET (RF_RESET)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_fmt = IMM_NONE;
    case (opcode)
      OP_R: begin
        ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM: begin
        ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OP_FUNCT);
        use_rs1 = 1'b1;
        imm_fmt = IMM_I;
      end
      OP_LOAD: begin
        ctrl    = pack_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_OP_ADD);
        use_rs1 = 1'b1;
        imm_fmt = IMM_I;
      end
      OP_STORE: begin
        ctrl    = pack_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_OP_ADD);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_fmt = IMM_S;
      end
      OP_BRANCH: begin
        ctrl    = pack_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_BRANCH);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_fmt = IMM_B;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_fmt)
      IMM_I: imm = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
      IMM_S: imm = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
      IMM_B: imm = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                    if_id_instr[30:25], if_id_instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  // A load in EX whose destination feeds this instruction needs one bubble.
  assign load_use = id_ex_valid && id_ex_ctrl[CTRL_MEM_READ] && (id_ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == id_ex_rd)) || (use_rs2 && (rs2 == id_ex_rd)));

  // A squashed instruction must never freeze fetch.
  assign stall = load_use && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush || load_use) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_funct3   <= '0;
      id_ex_funct7b5 <= 1'b0;
      id_ex_ctrl     <= '0;
      id_ex_illegal  <= 1'b0;
    end else begin
      id_ex_valid    <= 1'b1;
      id_ex_pc       <= if_id_npc - XLEN'(4);
      id_ex_rs1_data <= rs1_data;
      id_ex_rs2_data <= rs2_data;
      id_ex_imm      <= imm;
      id_ex_rs1      <= rs1;
      id_ex_rs2      <= rs2;
      id_ex_rd       <= rd;
      id_ex_funct3   <= funct3;
      id_ex_funct7b5 <= funct7b5;
      id_ex_ctrl     <= ctrl;
      id_ex_illegal  <= illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: driver pushes hand-computed ID/EX bundles into
// an expected queue; a monitor pops one per clock edge and compares.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [7:0]  ctrl;
    logic        illegal;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic [7:0]  id_ex_ctrl;
  logic        id_ex_illegal;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  id_stage #(.XLEN(32), .RF_RESET(1'b1)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_id_instr    (if_id_instr),
    .if_id_npc      (if_id_npc),
    .flush          (flush),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .stall          (stall),
    .id_ex_valid    (id_ex_valid),
    .id_ex_pc       (id_ex_pc),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_imm      (id_ex_imm),
    .id_ex_rs1      (id_ex_rs1),
    .id_ex_rs2      (id_ex_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_funct3   (id_ex_funct3),
    .id_ex_funct7b5 (id_ex_funct7b5),
    .id_ex_ctrl     (id_ex_ctrl),
    .id_ex_illegal  (id_ex_illegal)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] r1d,
                              input logic [31:0] r2d, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic f7, input logic [7:0] ctrl, input logic ill);
    exp_t e;
    e.valid = 1'b1;  e.pc = pc;    e.rs1_data = r1d; e.rs2_data = r2d;
    e.imm = imm;     e.rs1 = rs1;  e.rs2 = rs2;      e.rd = rd;
    e.funct3 = f3;   e.funct7b5 = f7; e.ctrl = ctrl; e.illegal = ill;
    return e;
  endfunction

  localparam exp_t BUB = '0;

  // driver: one call per cycle; drives at negedge, checks combinational stall
  task automatic step(input string nm, input logic rst, input logic fl,
                      input logic [31:0] instr, input logic [31:0] npc,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic exp_stall, input exp_t e);
    @(negedge clock);
    reset = rst; flush = fl; if_id_instr = instr; if_id_npc = npc;
    wb_we = we; wb_rd = wrd; wb_data = wdat;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    vectors++;
    if (stall !== exp_stall) begin
      miscompares++;
      $display("FAIL %s.stall: got %b expected %b", nm, stall, exp_stall);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t  got;
    exp_t  e;
    string nm;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got.valid = id_ex_valid;       got.pc = id_ex_pc;
        got.rs1_data = id_ex_rs1_data; got.rs2_data = id_ex_rs2_data;
        got.imm = id_ex_imm;           got.rs1 = id_ex_rs1;
        got.rs2 = id_ex_rs2;           got.rd = id_ex_rd;
        got.funct3 = id_ex_funct3;     got.funct7b5 = id_ex_funct7b5;
        got.ctrl = id_ex_ctrl;         got.illegal = id_ex_illegal;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s.id_ex: got %h expected %h", nm, got, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; if_id_instr = '0; if_id_npc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    @(posedge clock);
    step("reset0", 1, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, BUB);
    step("reset1", 1, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, BUB);
    // register setup behind flushed bubbles
    step("wb_x5", 0, 1, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 0, BUB);
    step("wb_x3", 0, 1, 32'h0, 32'h0, 1, 5'd3, 32'h3333, 0, BUB);
    step("wb_x1", 0, 1, 32'h0, 32'h0, 1, 5'd1, 32'h1000, 0, BUB);
    step("wb_x2", 0, 1, 32'h0, 32'h0, 1, 5'd2, 32'h0200, 0, BUB);
    // add x6,x5,x0 while writing x0 (must be ignored)
    step("add_x0w", 0, 0, 32'h00028333, 32'h104, 1, 5'd0, 32'hFFFF, 0,
         mk(32'h100, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 3'd0, 1'b0, 8'h82, 1'b0));
    // addi x8,x7,-1 with x7 written the same cycle
    step("addi_wt", 0, 0, 32'hFFF38413, 32'h108, 1, 5'd7, 32'hA5A5, 0,
         mk(32'h104, 32'hA5A5, 32'h0, 32'hFFFFFFFF, 5'd7, 5'd31, 5'd8, 3'd0, 1'b1, 8'h8A, 1'b0));
    // lw x9,0(x2); add x10,x9,x3 -> one bubble
    step("lw1", 0, 0, 32'h00012483, 32'h10C, 0, 5'd0, 32'h0, 0,
         mk(32'h108, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("add_stall", 0, 0, 32'h00348533, 32'h110, 1, 5'd9, 32'h9999, 1, BUB);
    step("add_go", 0, 0, 32'h00348533, 32'h110, 0, 5'd0, 32'h0, 0,
         mk(32'h10C, 32'h9999, 32'h3333, 32'h0, 5'd9, 5'd3, 5'd10, 3'd0, 1'b0, 8'h82, 1'b0));
    // lw x9; sw x9,4(x1) -> stall through rs2
    step("lw2", 0, 0, 32'h00012483, 32'h114, 0, 5'd0, 32'h0, 0,
         mk(32'h110, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("sw_stall", 0, 0, 32'h0090A223, 32'h118, 0, 5'd0, 32'h0, 1, BUB);
    step("sw_go", 0, 0, 32'h0090A223, 32'h118, 0, 5'd0, 32'h0, 0,
         mk(32'h114, 32'h1000, 32'h9999, 32'h4, 5'd1, 5'd9, 5'd4, 3'd2, 1'b0, 8'h28, 1'b0));
    // lw x9; addi x11,x1,1 -> no stall (rs2 field 9? no: rs2 field is 1, unused)
    step("lw3", 0, 0, 32'h00012483, 32'h11C, 0, 5'd0, 32'h0, 0,
         mk(32'h118, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("addi_nost", 0, 0, 32'h00108593, 32'h120, 0, 5'd0, 32'h0, 0,
         mk(32'h11C, 32'h1000, 32'h1000, 32'h1, 5'd1, 5'd1, 5'd11, 3'd0, 1'b0, 8'h8A, 1'b0));
    // lw x0; add x10,x0,x3 -> no stall
    step("lw_x0", 0, 0, 32'h00012003, 32'h124, 0, 5'd0, 32'h0, 0,
         mk(32'h120, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("add_x0dep", 0, 0, 32'h00300533, 32'h128, 0, 5'd0, 32'h0, 0,
         mk(32'h124, 32'h0, 32'h3333, 32'h0, 5'd0, 5'd3, 5'd10, 3'd0, 1'b0, 8'h82, 1'b0));
    // flush during load-use: stall gated, bubble
    step("lw4", 0, 0, 32'h00012483, 32'h12C, 0, 5'd0, 32'h0, 0,
         mk(32'h128, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("flush_stall", 0, 1, 32'h00348533, 32'h130, 0, 5'd0, 32'h0, 0, BUB);
    // beq x1,x2,-8
    step("beq", 0, 0, 32'hFE208CE3, 32'h130, 0, 5'd0, 32'h0, 0,
         mk(32'h12C, 32'h1000, 32'h200, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 3'd0, 1'b1, 8'h05, 1'b0));
    // opcode 0x7F
    step("illegal", 0, 0, 32'h0020807F, 32'h134, 0, 5'd0, 32'h0, 0,
         mk(32'h130, 32'h1000, 32'h200, 32'h0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1));
    // reset during a load-use stall; regfile cleared afterwards
    step("lw5", 0, 0, 32'h00012483, 32'h138, 0, 5'd0, 32'h0, 0,
         mk(32'h134, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd9, 3'd2, 1'b0, 8'hD8, 1'b0));
    step("rst_stall", 1, 0, 32'h00348533, 32'h13C, 0, 5'd0, 32'h0, 1, BUB);
    step("after_rst", 0, 0, 32'h00348533, 32'h13C, 0, 5'd0, 32'h0, 0,
         mk(32'h138, 32'h0, 32'h0, 32'h0, 5'd9, 5'd3, 5'd10, 3'd0, 1'b0, 8'h82, 1'b0));
    // drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
